// File: rtl/ulpi_pkg.sv
// ulpi_pkg: definitions shared by the ULPI link controller and the RX decoder.
// Holds the receive-side state encoding, the RX CMD field positions and the
// RxEvent encodings carried in RX CMD bits [5:4].
package ulpi_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_TURN = 2'd1,
    RX_BUS  = 2'd2,
    RX_PKT  = 2'd3
  } ulpi_rx_state;

  // RX CMD byte layout
  localparam int RXCMD_LS_LO   = 0;
  localparam int RXCMD_LS_HI   = 1;
  localparam int RXCMD_VBUS_LO = 2;
  localparam int RXCMD_VBUS_HI = 3;
  localparam int RXCMD_EVT_LO  = 4;
  localparam int RXCMD_EVT_HI  = 5;
  localparam int RXCMD_ID      = 6;
  localparam int RXCMD_ALTINT  = 7;

  // RxEvent field values; bit 0 doubles as RxActive
  localparam logic [1:0] RXEV_NONE     = 2'b00;
  localparam logic [1:0] RXEV_ACTIVE   = 2'b01;
  localparam logic [1:0] RXEV_HOSTDISC = 2'b10;
  localparam logic [1:0] RXEV_ERROR    = 2'b11;

endpackage

// File: rtl/ulpi_rx_decoder_if.sv
// ulpi_rx_decoder_if: PHY receive signals plus the decoded packet stream and
// RX CMD status outputs of ulpi_rx_decoder.
//   i_dir, i_nxt, i_data         : PHY dir / nxt / data as sampled on the ULPI clock
//   o_rx_data/valid/last/error   : received packet byte stream (no backpressure)
//   o_linestate, o_vbus_state,
//   o_host_disc, o_id            : last decoded RX CMD status
//   o_rxcmd_stb                  : one-cycle pulse when the status fields update
// Modports: slave = decoder side, master = PHY/consumer side.
interface ulpi_rx_decoder_if;
  logic       i_dir;
  logic       i_nxt;
  logic [7:0] i_data;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_last;
  logic       o_rx_error;
  logic [1:0] o_linestate;
  logic [1:0] o_vbus_state;
  logic       o_host_disc;
  logic       o_id;
  logic       o_rxcmd_stb;

  modport slave (
    input  i_dir, i_nxt, i_data,
    output o_rx_data, o_rx_valid, o_rx_last, o_rx_error,
    output o_linestate, o_vbus_state, o_host_disc, o_id, o_rxcmd_stb
  );

  modport master (
    output i_dir, i_nxt, i_data,
    input  o_rx_data, o_rx_valid, o_rx_last, o_rx_error,
    input  o_linestate, o_vbus_state, o_host_disc, o_id, o_rxcmd_stb
  );
endinterface

// File: rtl/ulpi_rx_stats.sv
// ulpi_rx_stats: receive statistics counters for ulpi_rx_decoder.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_pkt_ev     : a packet ended with last and no error
//   i_err_ev     : a packet ended with last and error
//   i_drop_ev    : a zero-length packet or an out-of-packet data byte
//   o_pkt_cnt, o_err_cnt, o_drop_cnt : 16-bit wrapping counts
module ulpi_rx_stats (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pkt_ev,
  input  logic        i_err_ev,
  input  logic        i_drop_ev,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_drop_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pkt_cnt  <= '0;
      o_err_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (i_pkt_ev)  o_pkt_cnt  <= o_pkt_cnt + 16'd1;
      if (i_err_ev)  o_err_cnt  <= o_err_cnt + 16'd1;
      if (i_drop_ev) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ulpi_rx_decoder.sv
// ulpi_rx_decoder: splits the ULPI receive stream into RX CMD status updates
// and framed USB packet bytes.
//   i_clk, i_rst : ULPI clock, synchronous active-high reset
//   bus          : ulpi_rx_decoder_if.slave (PHY inputs, packet stream, status)
// Optional build macro ULPI_RX_STATS_EN adds o_pkt_cnt, o_err_cnt, o_drop_cnt.
// Each data byte is parked in a one-byte hold register so that it can be
// tagged as last when the end of packet is seen one or more cycles later.
module ulpi_rx_decoder
  import ulpi_pkg::*;
#(
  parameter int PKT_MAX_LEN = 1027,
  parameter int LEN_W       = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ulpi_rx_decoder_if.slave bus
`ifdef ULPI_RX_STATS_EN
  ,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_drop_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = RX_IDLE;
  localparam logic [1:0] ST_TURN = RX_TURN;
  localparam logic [1:0] ST_BUS  = RX_BUS;
  localparam logic [1:0] ST_PKT  = RX_PKT;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PKT_MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(PKT_MAX_LEN + 1);

  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] len_in);
    return (len_in >= LEN_SAT) ? LEN_SAT : len_in + 1'b1;
  endfunction

  logic [1:0]       state, state_n;
  logic             pkt_pending, pend_n;
  logic [7:0]       hold_data;
  logic             hold_full, full_n;
  logic [LEN_W-1:0] len, len_n;
  logic             sticky, sticky_n;
  logic             store, upd_cmd, eop, eop_force, eop_err;
  logic [1:0]       rxev;

  assign rxev    = bus.i_data[RXCMD_EVT_HI:RXCMD_EVT_LO];
  // An abort always reports an error, regardless of the sticky flag
  assign eop_err = sticky | eop_force;

  always_comb begin
    state_n   = state;
    pend_n    = pkt_pending;
    full_n    = hold_full;
    len_n     = len;
    sticky_n  = sticky;
    store     = 1'b0;
    upd_cmd   = 1'b0;
    eop       = 1'b0;
    eop_force = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_dir) begin
          state_n = ST_TURN;
          pend_n  = bus.i_nxt;
        end
      end
      ST_TURN: begin
        pend_n = 1'b0;
        if (!bus.i_dir)       state_n = ST_IDLE;
        else if (pkt_pending) state_n = ST_PKT;
        else                  state_n = ST_BUS;
      end
      ST_BUS: begin
        if (!bus.i_dir) begin
          state_n = ST_IDLE;
        end else if (bus.i_nxt) begin
          // Stray data byte outside a packet: discarded, but it implies RxActive
          state_n = ST_PKT;
        end else begin
          upd_cmd = 1'b1;
          if (rxev[0]) state_n = ST_PKT;
        end
      end
      ST_PKT: begin
        if (!bus.i_dir) begin
          eop       = 1'b1;
          eop_force = 1'b1;
          state_n   = ST_IDLE;
        end else if (bus.i_nxt) begin
          if (len < LEN_MAX) begin
            store  = 1'b1;
            full_n = 1'b1;
          end else begin
            sticky_n = 1'b1;
          end
          len_n = len_sat_inc(len);
        end else begin
          upd_cmd = 1'b1;
          if (rxev == RXEV_ERROR) sticky_n = 1'b1;
          if (!rxev[0]) begin
            eop     = 1'b1;
            state_n = ST_BUS;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (eop) begin
      full_n   = 1'b0;
      len_n    = '0;
      sticky_n = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      pkt_pending      <= 1'b0;
      hold_full        <= 1'b0;
      len              <= '0;
      sticky           <= 1'b0;
      bus.o_rx_data    <= '0;
      bus.o_rx_valid   <= 1'b0;
      bus.o_rx_last    <= 1'b0;
      bus.o_rx_error   <= 1'b0;
      bus.o_linestate  <= '0;
      bus.o_vbus_state <= '0;
      bus.o_host_disc  <= 1'b0;
      bus.o_id         <= 1'b0;
      bus.o_rxcmd_stb  <= 1'b0;
    end else begin
      state          <= state_n;
      pkt_pending    <= pend_n;
      hold_full      <= full_n;
      len            <= len_n;
      sticky         <= sticky_n;
      bus.o_rx_valid <= (store | eop) & hold_full;
      bus.o_rx_last  <= eop & hold_full;
      bus.o_rx_error <= eop & hold_full & eop_err;
      if ((store | eop) & hold_full) bus.o_rx_data <= hold_data;
      bus.o_rxcmd_stb <= upd_cmd;
      if (upd_cmd) begin
        bus.o_linestate  <= bus.i_data[RXCMD_LS_HI:RXCMD_LS_LO];
        bus.o_vbus_state <= bus.i_data[RXCMD_VBUS_HI:RXCMD_VBUS_LO];
        bus.o_host_disc  <= (rxev == RXEV_HOSTDISC);
        bus.o_id         <= bus.i_data[RXCMD_ID];
      end
    end
  end

  // Hold register data; validity is tracked by hold_full
  always_ff @(posedge i_clk) begin
    if (store) hold_data <= bus.i_data;
  end

`ifdef ULPI_RX_STATS_EN
  logic oop_byte;
  assign oop_byte = (state == ST_BUS) & bus.i_dir & bus.i_nxt;

  ulpi_rx_stats u_stats (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pkt_ev   (eop & hold_full & ~eop_err),
    .i_err_ev   (eop & hold_full & eop_err),
    .i_drop_ev  ((eop & ~hold_full) | oop_byte),
    .o_pkt_cnt  (o_pkt_cnt),
    .o_err_cnt  (o_err_cnt),
    .o_drop_cnt (o_drop_cnt)
  );
`endif

endmodule

// File: tb/tb_ulpi_rx_decoder.sv
module tb_ulpi_rx_decoder;
  localparam int MAXL = 4;

  logic clk;
  logic rst;
  ulpi_rx_decoder_if bus_if();

`ifdef ULPI_RX_STATS_EN
  logic [15:0] pkt_cnt, err_cnt, drop_cnt;
`endif

  ulpi_rx_decoder #(.PKT_MAX_LEN(MAXL), .LEN_W(11)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
`ifdef ULPI_RX_STATS_EN
    ,
    .o_pkt_cnt  (pkt_cnt),
    .o_err_cnt  (err_cnt),
    .o_drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pkt  = 0;
  int exp_err  = 0;
  int exp_drop = 0;

  logic [9:0] exp_rx_q[$];   // {error, last, data}
  logic [7:0] exp_st_q[$];   // RX CMD bytes expected to update status
  logic [7:0] pkt_q[$];
  logic [7:0] cmd_q[$];

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (bus_if.o_rx_valid) begin
      n_checks++;
      if (exp_rx_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got data=%h last=%b err=%b, required no output",
                 bus_if.o_rx_data, bus_if.o_rx_last, bus_if.o_rx_error);
      end else begin
        logic [9:0] e;
        e = exp_rx_q.pop_front();
        if (bus_if.o_rx_data !== e[7:0] || bus_if.o_rx_last !== e[8] ||
            (e[8] && bus_if.o_rx_error !== e[9])) begin
          n_fail++;
          $display("FAIL rx_byte: got data=%h last=%b err=%b, required data=%h last=%b err=%b",
                   bus_if.o_rx_data, bus_if.o_rx_last, bus_if.o_rx_error, e[7:0], e[8], e[9]);
        end
      end
    end
    if (bus_if.o_rxcmd_stb) begin
      n_checks++;
      if (exp_st_q.size() == 0) begin
        n_fail++;
        $display("FAIL status_unexpected: strobe with no RX CMD sent");
      end else begin
        logic [7:0] c;
        c = exp_st_q.pop_front();
        if (bus_if.o_linestate !== c[1:0] || bus_if.o_vbus_state !== c[3:2] ||
            bus_if.o_host_disc !== (c[5:4] == 2'b10) || bus_if.o_id !== c[6]) begin
          n_fail++;
          $display("FAIL status: got ls=%b vbus=%b hd=%b id=%b, required from cmd %h",
                   bus_if.o_linestate, bus_if.o_vbus_state, bus_if.o_host_disc, bus_if.o_id, c);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic d, input logic n, input logic [7:0] b);
    @(negedge clk);
    bus_if.i_dir  = d;
    bus_if.i_nxt  = n;
    bus_if.i_data = b;
  endtask

  function automatic logic [7:0] rcmd(input logic [1:0] ev);
    logic [7:0] b;
    b = 8'($urandom);
    b[5:4] = ev;
    return b;
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    exp_st_q.push_back(b);
    drive(1'b1, 1'b0, b);
  endtask

  task automatic session_status();
    drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b1, 1'b0, 8'($urandom));
    foreach (cmd_q[i]) send_cmd(cmd_q[i]);
    drive(1'b0, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // entry: 0 = RxActive shortcut at dir rise, 1 = RX CMD with RxActive, 2 = stray data byte
  task automatic session_pkt(input int entry, input int err_pos, input logic [7:0] err_cmd,
                             input logic [7:0] end_cmd, input bit abort, input bit mid);
    int  n, m;
    bit  will_err;
    n = pkt_q.size();
    m = (n > MAXL) ? MAXL : n;
    will_err = abort || (err_pos >= 0 && err_pos <= n) || (n > MAXL);
    for (int i = 0; i < m; i++)
      exp_rx_q.push_back({(i == m - 1) ? will_err : 1'b0, (i == m - 1), pkt_q[i]});
    if (n == 0) exp_drop++;
    else if (will_err) exp_err++;
    else exp_pkt++;

    if (entry == 0) begin
      drive(1'b1, 1'b1, 8'($urandom));
      drive(1'b1, 1'b0, 8'($urandom));
    end else begin
      drive(1'b1, 1'b0, 8'($urandom));
      drive(1'b1, 1'b0, 8'($urandom));
      if (entry == 1) send_cmd(rcmd(2'b01));
      else begin
        exp_drop++;
        drive(1'b1, 1'b1, 8'($urandom));
      end
    end
    for (int i = 0; i <= n; i++) begin
      if (i == err_pos) send_cmd(err_cmd);
      if (i < n) begin
        if (mid && $urandom_range(0, 3) == 0) send_cmd(rcmd(2'b01));
        drive(1'b1, 1'b1, pkt_q[i]);
      end
    end
    if (abort) drive(1'b0, 1'b0, 8'($urandom));
    else begin
      send_cmd(end_cmd);
      drive(1'b0, 1'b0, 8'($urandom));
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero();
    check("rst_rx_valid", 16'(bus_if.o_rx_valid), 16'd0);
    check("rst_rx_last", 16'(bus_if.o_rx_last), 16'd0);
    check("rst_rx_error", 16'(bus_if.o_rx_error), 16'd0);
    check("rst_rx_data", 16'(bus_if.o_rx_data), 16'd0);
    check("rst_linestate", 16'(bus_if.o_linestate), 16'd0);
    check("rst_vbus", 16'(bus_if.o_vbus_state), 16'd0);
    check("rst_host_disc", 16'(bus_if.o_host_disc), 16'd0);
    check("rst_id", 16'(bus_if.o_id), 16'd0);
    check("rst_rxcmd_stb", 16'(bus_if.o_rxcmd_stb), 16'd0);
`ifdef ULPI_RX_STATS_EN
    check("rst_pkt_cnt", pkt_cnt, 16'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus_if.i_dir  = 1'b0;
    bus_if.i_nxt  = 1'b0;
    bus_if.i_data = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);

    // RX CMD 4D: linestate 01, vbus 11, id 1
    cmd_q = '{8'h4D};
    session_status();
    check("t1_linestate", 16'(bus_if.o_linestate), 16'h1);
    check("t1_vbus", 16'(bus_if.o_vbus_state), 16'h3);
    check("t1_id", 16'(bus_if.o_id), 16'h1);
    check("t1_host_disc", 16'(bus_if.o_host_disc), 16'h0);

    // Clean packet, then same packet with RxError, then abort, then overflow
    pkt_q = '{8'hA5, 8'h5A, 8'hC3};
    session_pkt(0, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    session_pkt(0, 3, 8'h31, 8'h00, 1'b0, 1'b0);
    pkt_q = '{8'h11, 8'h22};
    session_pkt(0, -1, 8'h00, 8'h00, 1'b1, 1'b0);
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    session_pkt(0, -1, 8'h00, 8'h00, 1'b0, 1'b0);
    // Status holds after dir falls
    check("hold_linestate", 16'(bus_if.o_linestate), 16'h0);

    // Reset while 7E sits in the hold register
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h7E);
    @(negedge clk);
    rst = 1'b1;
    bus_if.i_nxt = 1'b0;
    @(negedge clk);
    check_all_zero();
    bus_if.i_dir = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_pkt = 0; exp_err = 0; exp_drop = 0;
    drive(1'b0, 1'b0, 8'h00);
    pkt_q = '{8'hA5, 8'h5A, 8'hC3};
    session_pkt(0, -1, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized sessions
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        cmd_q.delete();
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) cmd_q.push_back(rcmd($urandom_range(0, 1) ? 2'b10 : 2'b00));
        session_status();
      end else begin
        int n, ep;
        pkt_q.delete();
        n = $urandom_range(0, 7);
        for (int j = 0; j < n; j++) pkt_q.push_back(8'($urandom));
        ep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
        session_pkt($urandom_range(0, 2), ep, rcmd(2'b11),
                    rcmd($urandom_range(0, 1) ? 2'b10 : 2'b00),
                    ($urandom_range(0, 4) == 0), 1'b1);
      end
    end
    repeat (4) drive(1'b0, 1'b0, 8'h00);

    check("rx_queue_drained", 16'(exp_rx_q.size()), 16'd0);
    check("status_queue_drained", 16'(exp_st_q.size()), 16'd0);
`ifdef ULPI_RX_STATS_EN
    check("pkt_cnt", pkt_cnt, 16'(exp_pkt));
    check("err_cnt", err_cnt, 16'(exp_err));
    check("drop_cnt", drop_cnt, 16'(exp_drop));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ulpi_rx_decoder.md
Name: ulpi_rx_decoder

Overview:
- Downstream of the ULPI link controller, on the same ULPI clock; samples dir/nxt/data exactly as the PHY drives them.
- Separates RX CMD bytes from USB receive data and decodes RX CMD fields into registered status outputs.
- Frames received USB bytes into a packet stream with last/error marking.
- Feeds the USB packet layer. ULPI cannot be stalled, so the output has no backpressure.

Parameters:
- PKT_MAX_LEN, 1027: maximum accepted data bytes per packet; longer packets are truncated and flagged as errors.
- LEN_W, 11: width of the internal byte counter; must hold PKT_MAX_LEN+1.

Ports:
- i_clk  in  1  ULPI 60 MHz clock.
- i_rst  in  1  synchronous active-high reset.
- i_dir  in  1  PHY dir.
- i_nxt  in  1  PHY nxt.
- i_data  in  8  PHY data bus.
- o_rx_data  out  8  received USB byte.
- o_rx_valid  out  1  o_rx_data valid this cycle.
- o_rx_last  out  1  qualifies o_rx_valid; final byte of packet.
- o_rx_error  out  1  qualifies o_rx_last; packet had RxError, abort or overflow.
- o_linestate  out  2  RX CMD bits [1:0].
- o_vbus_state  out  2  RX CMD bits [3:2].
- o_host_disc  out  1  RxEvent==2'b10.
- o_id  out  1  RX CMD bit 6.
- o_rxcmd_stb  out  1  one-cycle pulse when status outputs updated.

Behaviour:
- Reset: i_rst, synchronous, active-high, clock i_clk. Reset wins over every other event.
  - All outputs 0; state IDLE; hold register empty; length 0; sticky error 0.
  - Reset mid-packet: the held byte is discarded and no last is emitted.
- States: IDLE, TURN, BUS, PKT.
  - IDLE: i_dir==1 → TURN. If i_nxt==1 in that same cycle (PHY RxActive shortcut), → TURN with the pkt_pending flag set.
  - TURN: turnaround cycle, i_data ignored.
    - i_dir==0 → IDLE.
    - pkt_pending → PKT.
    - Otherwise → BUS.
  - BUS: dir high, no packet.
    - nxt==0: byte is an RX CMD; update status outputs and pulse o_rxcmd_stb.
    - RxEvent[0]==1 (RxActive) → PKT.
    - nxt==1 in BUS: data byte outside a packet; the byte is ignored and the block enters PKT.
    - i_dir==0 → IDLE.
  - PKT, nxt==1: data byte.
    - If length < PKT_MAX_LEN, store it in the hold register. If the hold register was already full, emit the previous byte with valid=1, last=0.
    - If length ≥ PKT_MAX_LEN, drop the byte and set sticky error.
    - Length saturates at PKT_MAX_LEN+1.
  - PKT, nxt==0: RX CMD; update status.
    - RxEvent==2'b11: set sticky error.
    - RxActive==0: end of packet → BUS.
  - PKT, i_dir==0 (abort): end of packet with sticky error forced → IDLE.
- End of packet:
  - If the hold register is full, emit it with valid=1, last=1, error=sticky, then clear hold, length and sticky.
  - Zero-byte packet: no output.
- Timing:
  - All outputs are registered. Byte N appears one cycle after the edge that samples byte N+1 or the end event.
  - o_rx_valid is never asserted in consecutive cycles for the same byte.
- Status outputs hold their value between RX CMDs and are not cleared by dir falling.

Optional Feature:
- Macro ULPI_RX_STATS_EN.
- When defined, add ports:
  - o_pkt_cnt  out 16: packets ending with last and error=0.
  - o_err_cnt  out 16: packets ending with error=1.
  - o_drop_cnt  out 16: zero-length packets plus out-of-packet data bytes.
- Counters wrap at 16'hFFFF→0, clear on i_rst, and increment in the same cycle as the corresponding o_rx_last or drop.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Decomposition:
- ulpi_pkg, shared with the link controller:
  - ulpi_rx_state enum (IDLE/TURN/BUS/PKT).
  - RX CMD field index constants.
  - RxEvent encodings RXEV_NONE=2'b00, RXEV_ACTIVE=2'b01, RXEV_HOSTDISC=2'b10, RXEV_ERROR=2'b11.
- One sub-module: ulpi_rx_stats, holding the three counters, instantiated only under ULPI_RX_STATS_EN.

Test Plan:
- dir 0→1, TURN, RX CMD 8'h4D (nxt=0), dir→0 → o_linestate=2'b01, o_vbus_state=2'b11, o_id=1, o_host_disc=0, one o_rxcmd_stb, no o_rx_valid.
- dir↑ with nxt↑, data A5,5A,C3 (nxt=1), RX CMD 8'h00 → three valid bytes A5,5A,C3; last only on C3; error=0.
- Same packet with RX CMD 8'h31 mid-packet before the end → C3 emitted with last=1, error=1.
- dir falls after data 11,22 without RxActive deassert → 11 (last=0), 22 (last=1, error=1); state IDLE.
- PKT_MAX_LEN=4, send 6 bytes 01..06 → 01..04 emitted, 04 with last=1, error=1.
- i_rst pulsed while the hold register holds 7E mid-packet → no valid/last emitted; all outputs 0; next packet decodes normally; stats (if enabled) 0.
